// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch front end.
package riscv_pkg;

  // add x0, x0, x0: harmless filler for squashed or invalid fetches
  localparam logic [31:0] NOP_WORD = 32'h0000_0033;

  // Base-ISA major opcodes (instruction bits 6:0)
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Program-loader states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/inst_loader_fsm.sv
// Byte-stream program loader: assembles little-endian bytes into words and
// emits one write strobe per completed word into the instruction RAM.
module inst_loader_fsm
  import riscv_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH),
  localparam int BPW    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_byte_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [AW:0]       ld_count,
  output logic              busy,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int            LW        = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(BPW - 1);
  localparam logic [AW:0]   LAST_WORD = (AW + 1)'(DEPTH - 1);

  ld_state_t         state_reg, state_next;
  logic [LW-1:0]     lane_reg;
  logic [AW:0]       count_reg;
  logic [DATA_W-1:0] word_reg;
  logic [DATA_W-1:0] word_next;
  logic              byte_accept;
  logic              word_write;
  logic              last_write;

  assign byte_accept = ld_byte_valid && (state_reg == LOAD);
  assign word_write  = byte_accept && (lane_reg == LAST_LANE);
  assign last_write  = word_write && (count_reg == LAST_WORD);

  // The incoming byte replaces its lane; the top lane of a finished word is
  // taken straight from ld_byte so the RAM write lands on the same edge.
  generate
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (lane_reg == LW'(gi)) ? ld_byte : word_reg[8*gi +: 8];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state: a byte arriving with ld_start is still taken before DONE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ld_start) state_next = LOAD;
      LOAD:    if (ld_start || last_write) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane, word pointer/count and assembly buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_reg  <= '0;
      count_reg <= '0;
      word_reg  <= '0;
    end else if (state_reg == IDLE && ld_start) begin
      lane_reg  <= '0;
      count_reg <= '0;
    end else if (byte_accept) begin
      word_reg <= word_next;
      if (word_write) begin
        lane_reg  <= '0;
        count_reg <= count_reg + 1'b1;
      end else begin
        lane_reg <= lane_reg + LW'(1);
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign ld_ready = (state_reg == LOAD);
  assign ld_done  = (state_reg == DONE);
  assign ld_count = count_reg;
  assign wr_en    = word_write;
  assign wr_addr  = count_reg[AW-1:0];
  assign wr_data  = word_next;

endmodule

// File: rtl/inst_mem_loadable.sv
// Run-time loadable instruction memory with a one-cycle registered fetch port
// (stall/flush aware) and a byte-stream loader.
module inst_mem_loadable
  import riscv_pkg::*;
#(
  parameter  int                DATA_W   = 32,
  parameter  int                DEPTH    = 64,
  parameter  int                PC_W     = 32,
  parameter  logic [DATA_W-1:0] NOP_WORD = riscv_pkg::NOP_WORD,
  localparam int                AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              fetch_err,
  input  logic              ld_start,
  input  logic              ld_byte_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [AW:0]       ld_count,
  output logic              busy
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;
  logic              hit_reg;
  logic              inst_valid_reg;
  logic              fetch_err_reg;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     fetch_idx;
  logic              fetch_ok;
  logic              rd_en;

  inst_loader_fsm #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_loader (
    .clk           (clk),
    .rst           (rst),
    .ld_start      (ld_start),
    .ld_byte_valid (ld_byte_valid),
    .ld_byte       (ld_byte),
    .ld_ready      (ld_ready),
    .ld_done       (ld_done),
    .ld_count      (ld_count),
    .busy          (busy),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
  );

  // A fetch is legal only if word-aligned and every bit above the index is 0
  assign fetch_idx = fetch_pc[AW+1:2];
  assign fetch_ok  = (fetch_pc[1:0] == 2'b00)
                  && ((fetch_pc >> (AW + 2)) == '0)
                  && ({1'b0, fetch_idx} < (AW + 1)'(DEPTH));

  // RAM read only fires when the result will actually be presented, so the
  // read register doubles as the hold register during stall.
  assign rd_en = !busy && !flush && !stall && fetch_req && fetch_ok;

  // RAM write port (loader)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // RAM read port (fetch), kept reset-free so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_reg <= mem[fetch_idx];
  end

  // Fetch control: busy > flush > stall > request > idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_reg        <= 1'b0;
      inst_valid_reg <= 1'b0;
      fetch_err_reg  <= 1'b0;
    end else if (busy || flush) begin
      hit_reg        <= 1'b0;
      inst_valid_reg <= 1'b0;
      fetch_err_reg  <= 1'b0;
    end else if (!stall) begin
      hit_reg        <= fetch_req && fetch_ok;
      inst_valid_reg <= fetch_req;
      fetch_err_reg  <= fetch_req && !fetch_ok;
    end
  end

  assign inst_out   = hit_reg ? rd_data_reg : NOP_WORD;
  assign inst_valid = inst_valid_reg;
  assign fetch_err  = fetch_err_reg;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Self-checking bench for inst_mem_loadable (DEPTH=64, 32-bit words).
module tb_inst_mem_loadable;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        flush;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        fetch_err;
  logic        ld_start;
  logic        ld_byte_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ld_done;
  logic [6:0]  ld_count;
  logic        busy;

  always #5 clk = ~clk;

  inst_mem_loadable #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .PC_W   (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .fetch_pc      (fetch_pc),
    .stall         (stall),
    .flush         (flush),
    .inst_out      (inst_out),
    .inst_valid    (inst_valid),
    .fetch_err     (fetch_err),
    .ld_start      (ld_start),
    .ld_byte_valid (ld_byte_valid),
    .ld_byte       (ld_byte),
    .ld_ready      (ld_ready),
    .ld_done       (ld_done),
    .ld_count      (ld_count),
    .busy          (busy)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_model [DEPTH];
  bit          known     [DEPTH];
  logic [7:0]  stim [$];

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] exp_inst;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams every byte in stim, one per cycle, and models the load at the
  // byte/word level: every 4 accepted bytes form one little-endian word.
  task automatic load(input bit end_start, input bit start_with_last, output int words);
    int          phase;
    int          phase_next;
    int          cnt;
    int          lane;
    int          n;
    logic [31:0] asm_w;
    logic [7:0]  b;
    bit          was_busy;
    bit          strobe;
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    ld_start  = 1'b1;
    tick();
    ld_start = 1'b0;
    phase = 1; cnt = 0; lane = 0; asm_w = '0;
    chk("start_busy", busy, 1);
    chk("start_count", ld_count, 0);
    n = stim.size();
    for (int i = 0; i < n; i++) begin
      b             = stim.pop_front();
      ld_byte_valid = 1'b1;
      ld_byte       = b;
      strobe        = start_with_last && (i == n - 1);
      ld_start      = strobe;
      chk("ld_ready", ld_ready, phase == 1);
      chk("busy", busy, phase != 0);
      was_busy   = (phase != 0);
      phase_next = (phase == 2) ? 0 : phase;
      if (phase == 1) begin
        asm_w[8*lane +: 8] = b;
        lane++;
        if (lane == 4) begin
          mem_model[cnt] = asm_w;
          known[cnt]     = 1'b1;
          cnt++;
          lane = 0;
        end
        if (strobe || cnt == DEPTH) phase_next = 2;
      end
      tick();
      chk("ld_done", ld_done, phase_next == 2);
      if (was_busy) chk("fetch_blocked", inst_valid, 0);
      phase = phase_next;
    end
    ld_byte_valid = 1'b0;
    ld_start      = 1'b0;
    if (phase == 1 && end_start) begin
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      phase = 2;
      chk("ld_done_end", ld_done, 1);
    end
    if (phase != 1) chk("ld_count", ld_count, cnt);
    if (phase == 2) begin
      tick();
      phase = 0;
      chk("done_once", ld_done, 0);
      chk("busy_after", busy, 0);
    end
    fetch_req = 1'b0;
    words = cnt;
  endtask

  task automatic fetch_chk(input logic [31:0] pc);
    bit ok;
    ok = (pc[1:0] == 2'b00) && (pc < DEPTH * 4);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    tick();
    fetch_req = 1'b0;
    chk("fetch_valid", inst_valid, 1);
    chk("fetch_err", fetch_err, !ok);
    if (!ok) chk("fetch_nop", inst_out, NOP);
    else if (known[pc[7:2]]) chk("fetch_data", inst_out, mem_model[pc[7:2]]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [31:0] cur_inst;
    logic        cur_v;
    logic        cur_e;
    logic        r_req, r_stall, r_flush;
    logic [31:0] r_pc;
    int          kind;
    bit          ok;

    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    rst = 1'b0; fetch_req = 1'b0; fetch_pc = '0; stall = 1'b0; flush = 1'b0;
    ld_start = 1'b0; ld_byte_valid = 1'b0; ld_byte = '0;

    // Reset state
    #12;
    chk("rst_inst", inst_out, NOP);
    chk("rst_valid", inst_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_count", ld_count, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Two-word program load
    stim = '{8'h83, 8'h20, 8'h00, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00};
    load(1'b1, 1'b0, w);
    chk("load2_count", ld_count, 2);

    // Table-driven fetch / control priority vectors
    vecs[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_2083, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0050_0113, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0102, 1'b0, 1'b0, NOP,           1'b1, 1'b1};
    vecs[3]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, NOP,           1'b1, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_2083, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_2083, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0102, 1'b1, 1'b0, 32'h0000_2083, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_2083, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, NOP,           1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0050_0113, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, NOP,           1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0003, 1'b0, 1'b0, NOP,           1'b1, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, NOP,           1'b1, 1'b1};
    vecs[13] = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, NOP,           1'b1, 1'b1};
    vecs[14] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, NOP,           1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      fetch_req = vecs[i].req;
      fetch_pc  = vecs[i].pc;
      stall     = vecs[i].stall;
      flush     = vecs[i].flush;
      tick();
      chk($sformatf("vec%0d_inst", i), inst_out, vecs[i].exp_inst);
      chk($sformatf("vec%0d_valid", i), inst_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_err", i), fetch_err, vecs[i].exp_err);
    end
    fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();

    // Partial trailing word is dropped: only word 0 changes
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
    load(1'b1, 1'b0, w);
    chk("partial_count", ld_count, 1);
    fetch_chk(32'h4);
    chk("partial_keep_w1", inst_out, 32'h0050_0113);
    fetch_chk(32'h0);

    // ld_start arriving with the final byte still writes that word
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    load(1'b0, 1'b1, w);
    chk("same_cycle_count", ld_count, 2);
    fetch_chk(32'h0);
    fetch_chk(32'h4);

    // Fill the whole memory and overrun it by four bytes
    for (int i = 0; i < DEPTH * 4 + 4; i++) stim.push_back(8'($urandom));
    load(1'b0, 1'b0, w);
    chk("full_count", ld_count, DEPTH);

    // Randomised fetch traffic against the priority rules
    cur_inst = NOP; cur_v = 1'b0; cur_e = 1'b0;
    for (int i = 0; i < 300; i++) begin
      r_req   = ($urandom_range(0, 3) != 0);
      r_stall = (i != 0) && ($urandom_range(0, 4) == 0);
      r_flush = ($urandom_range(0, 7) == 0);
      kind    = $urandom_range(0, 7);
      if (kind < 6)       r_pc = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (kind == 6) r_pc = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
      else                r_pc = 32'(DEPTH * 4) + (32'($urandom_range(0, 1000)) * 4);
      ok = (r_pc[1:0] == 2'b00) && (r_pc < DEPTH * 4);
      if (r_flush) begin
        cur_inst = NOP; cur_v = 1'b0; cur_e = 1'b0;
      end else if (!r_stall) begin
        if (r_req) begin
          cur_inst = ok ? mem_model[r_pc[7:2]] : NOP;
          cur_v    = 1'b1;
          cur_e    = !ok;
        end else begin
          cur_inst = NOP; cur_v = 1'b0; cur_e = 1'b0;
        end
      end
      fetch_req = r_req; fetch_pc = r_pc; stall = r_stall; flush = r_flush;
      tick();
      chk("rnd_inst", inst_out, cur_inst);
      chk("rnd_valid", inst_valid, cur_v);
      chk("rnd_err", fetch_err, cur_e);
    end
    fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();

    // Reset in the middle of a load keeps the completed word
    for (int i = 0; i < 5; i++) stim.push_back(8'($urandom));
    load(1'b0, 1'b0, w);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ld_ready, 0);
    chk("midrst_count", ld_count, 0);
    chk("midrst_valid", inst_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midrst_nodone_a", ld_done, 0);
    tick();
    chk("midrst_nodone_b", ld_done, 0);
    fetch_chk(32'h0);
    fetch_chk(32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
